icache_nway_plru: RTL and testbench
===================================

// Module: icache_nway_plru
// PURPOSE
//  Parametrised N-way set-associative, read-only instruction cache between the core
//  fetch port and the word-wide instruction memory port. Next generation of the
//  team's X-way icache: configurable word width and replacement policy (round-robin
//  or tree pseudo-LRU), explicit FSM, whole-cache flush, hit/miss counters.
// PARAMETERS
//  CACHE_SIZE  2048  total data capacity in bytes
//  NUM_WAYS    4     ways per set; power of 2, >=2
//  NUM_BLOCKS  4     words per line; power of 2, >=2
//  WORD_BYTES  4     bytes per word/beat; power of 2; also address word granularity
//  REPL_POLICY 1     0 = per-set round-robin pointer, 1 = per-set tree pseudo-LRU
// PORTS
//  clk            in   1               clock, rising edge
//  resetn         in   1               asynchronous, active-low reset
//  proc_valid     in   1               fetch request; hold with proc_addr until proc_ready
//  proc_ready     out  1               one-cycle pulse: proc_rdata valid
//  proc_addr      in   32              byte address; low log2(WORD_BYTES) bits ignored
//  proc_rdata     out  8*WORD_BYTES    fetched word
//  flush_req      in   1               pulse: invalidate all lines
//  mem_req_valid  out  1               refill beat request
//  mem_req_ready  in   1               beat done; mem_req_rdata valid this cycle
//  mem_req_addr   out  32              word-aligned beat address
//  mem_req_rdata  in   8*WORD_BYTES    beat data
//  hit_count      out  32              saturating count of hits
//  miss_count     out  32              saturating count of misses
// BEHAVIOUR
//  Address split: tag | index (log2 sets) | word offset (log2 NUM_BLOCKS) | byte offset.
//  sets = CACHE_SIZE/(NUM_WAYS*NUM_BLOCKS*WORD_BYTES).
//  Reset (async): state IDLE; all valid bits, RR pointers, PLRU bits, counters = 0;
//   proc_ready=0, mem_req_valid=0, mem_req_addr=0, proc_rdata=0, flush pending=0.
//   Reset mid-refill abandons the beat immediately; partial line is never valid.
//  FSM: IDLE -> LOOKUP -> (hit) RESPOND -> IDLE; LOOKUP -> (miss) REFILL -> RESPOND.
//  IDLE: proc_valid=1 and no flush pending -> latch proc_addr, go LOOKUP.
//  LOOKUP: compare all ways in parallel. Hit: drive rdata, proc_ready=1 next cycle
//   (request-to-ready = 2 cycles), hit_count+1, update policy state for hit way.
//   Miss: miss_count+1, select victim: first invalid way (lowest index) else policy
//   victim; go REFILL with beat index = requested word (critical word first).
//  REFILL: mem_req_valid=1, mem_req_addr={line base, beat, 0s}. On mem_req_ready:
//   write beat into victim line; if beat == requested word, capture into proc_rdata;
//   beat increments modulo NUM_BLOCKS (wrap to 0). mem_req_valid drops for exactly
//   one cycle between beats. After NUM_BLOCKS beats: set tag, valid=1, update policy
//   (RR: pointer+1 mod NUM_WAYS; PLRU: mark filled way MRU), go RESPOND.
//  RESPOND: proc_ready=1 for one cycle; next cycle IDLE (back-to-back request
//   accepted no earlier than cycle after ready pulse).
//  proc_valid dropped during REFILL: refill completes, line installed, proc_ready
//   still pulses (requester ignores it); no abort.
//  Invalid way selection never touches policy state except on install/hit.
//  flush_req: in IDLE/LOOKUP/RESPOND clears all valid bits next edge (LOOKUP hit in
//   same cycle still responds). In REFILL: set flush pending; applied the cycle the
//   line installs (installed line also cleared); IDLE blocks new requests while pending.
//  Counters saturate at 32'hFFFFFFFF; never wrap.
//  mem_req_ready while mem_req_valid=0 is ignored.
// TESTING
//  Cold fetch 0x100, 4x4B words, beat ready 3 cyc after valid -> beats 0x100,0x104,
//   0x108,0x10C; proc_ready once; miss_count=1, hit_count=0.
//  Fetch 0x108 cold -> beat order 0x108,0x10C,0x100,0x104; rdata = beat 0x108 data.
//  Refetch 0x104 after fill -> proc_ready 2 cycles after proc_valid, no mem_req_valid.
//  NUM_WAYS=4 PLRU: fill 5 tags same set, touch way0 before 5th -> way0 survives, 
//   evicted way is PLRU way; REPL_POLICY=0 -> way0 evicted.
//  flush_req during beat 2 of refill -> refill completes, ready pulses, next fetch of
//   same line misses; resetn low mid-refill -> mem_req_valid 0 same cycle, all miss.
//  Force 2^32-1 hits via counter preload/force -> one more hit keeps hit_count saturated.

Source files
------------

// File: rtl/icache_nway_plru.sv
// N-way set-associative read-only instruction cache with round-robin or tree pseudo-LRU
// replacement, critical-word-first refill, whole-cache flush and saturating hit/miss counters.
module icache_nway_plru #(
    parameter int unsigned CACHE_SIZE  = 2048,
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned NUM_BLOCKS  = 4,
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned REPL_POLICY = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    proc_valid,
    output logic                    proc_ready,
    input  logic [31:0]             proc_addr,
    output logic [8*WORD_BYTES-1:0] proc_rdata,
    input  logic                    flush_req,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [31:0]             mem_req_addr,
    input  logic [8*WORD_BYTES-1:0] mem_req_rdata,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int unsigned DW       = 8 * WORD_BYTES;
    localparam int unsigned NUM_SETS = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * WORD_BYTES);
    localparam int unsigned BYTE_W   = $clog2(WORD_BYTES);
    localparam int unsigned OFF_W    = $clog2(NUM_BLOCKS);
    localparam int unsigned IDX_W    = $clog2(NUM_SETS);
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W    = 32 - IDX_W - OFF_W - BYTE_W;
    localparam int unsigned PLRU_W   = NUM_WAYS - 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_e;

    state_e                             state_q;
    logic [31:0]                        addr_q;
    logic [WAY_W-1:0]                   victim_q;
    logic [OFF_W-1:0]                   beat_q;
    logic [OFF_W-1:0]                   beat_cnt_q;
    logic                               flush_pend_q;
    logic                               proc_ready_q;
    logic [DW-1:0]                      proc_rdata_q;
    logic                               mem_req_valid_q;
    logic [31:0]                        mem_req_addr_q;
    logic [31:0]                        hit_cnt_q;
    logic [31:0]                        miss_cnt_q;
    logic [NUM_SETS*NUM_WAYS-1:0]       valid_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]     rr_q;
    logic [NUM_SETS-1:0][PLRU_W-1:0]    plru_q;

    logic [DW-1:0]    data_mem [NUM_SETS*NUM_WAYS*NUM_BLOCKS];
    logic [TAG_W-1:0] tag_mem  [NUM_SETS*NUM_WAYS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] pol_victim;
    logic [DW-1:0]    hit_data;
    logic             beat_done;
    logic             last_beat;
    logic             unused_addr_bits;

    assign req_tag          = addr_q[31 -: TAG_W];
    assign req_idx          = addr_q[BYTE_W+OFF_W +: IDX_W];
    assign req_off          = addr_q[BYTE_W +: OFF_W];
    assign unused_addr_bits = ^addr_q[BYTE_W-1:0];
    assign hit_data         = data_mem[{req_idx, hit_way, req_off}];
    assign pol_victim       = (REPL_POLICY == 0) ? rr_q[req_idx] : plru_victim;
    assign beat_done        = (state_q == REFILL) && mem_req_valid_q && mem_req_ready;
    assign last_beat        = (beat_cnt_q == OFF_W'(NUM_BLOCKS - 1));

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Point every tree node on the path to the touched way away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] cur,
                                                      input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        int                node;
        r    = cur;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            r[node] = ~way[WAY_W-1-l];
            node    = 2 * node + 1 + int'(way[WAY_W-1-l]);
        end
        return r;
    endfunction

    // Parallel tag compare plus lowest-index invalid way for victim selection.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (valid_q[{req_idx, WAY_W'(w)}] && (tag_mem[{req_idx, WAY_W'(w)}] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[{req_idx, WAY_W'(w)}]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    // Walk the PLRU tree toward the least-recently-used leaf.
    always_comb begin
        int node;
        node = 0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            node = 2 * node + 1 + int'(plru_q[req_idx][node]);
        end
        plru_victim = WAY_W'(node - int'(PLRU_W));
    end

    // Data and tag arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (beat_done) begin
            data_mem[{req_idx, victim_q, beat_q}] <= mem_req_rdata;
            if (last_beat) begin
                tag_mem[{req_idx, victim_q}] <= req_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            victim_q        <= '0;
            beat_q          <= '0;
            beat_cnt_q      <= '0;
            flush_pend_q    <= 1'b0;
            proc_ready_q    <= 1'b0;
            proc_rdata_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            valid_q         <= '0;
            rr_q            <= '0;
            plru_q          <= '0;
        end else begin
            proc_ready_q <= 1'b0;
            if (flush_req && (state_q != REFILL)) begin
                valid_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (proc_valid && !flush_pend_q) begin
                        addr_q  <= proc_addr;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        proc_rdata_q      <= hit_data;
                        proc_ready_q      <= 1'b1;
                        hit_cnt_q         <= sat_inc(hit_cnt_q);
                        plru_q[req_idx]   <= plru_touch(plru_q[req_idx], hit_way);
                        state_q           <= RESPOND;
                    end else begin
                        miss_cnt_q      <= sat_inc(miss_cnt_q);
                        victim_q        <= inv_found ? inv_way : pol_victim;
                        beat_q          <= req_off;
                        beat_cnt_q      <= '0;
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {req_tag, req_idx, req_off, BYTE_W'(0)};
                        state_q         <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush_req) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (!mem_req_valid_q) begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {req_tag, req_idx, beat_q, BYTE_W'(0)};
                    end else if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (beat_q == req_off) begin
                            proc_rdata_q <= mem_req_rdata;
                        end
                        beat_q     <= beat_q + OFF_W'(1);
                        beat_cnt_q <= beat_cnt_q + OFF_W'(1);
                        if (last_beat) begin
                            // A flush seen during the refill also drops the line just filled.
                            if (flush_pend_q || flush_req) begin
                                valid_q      <= '0;
                                flush_pend_q <= 1'b0;
                            end else begin
                                valid_q[{req_idx, victim_q}] <= 1'b1;
                            end
                            rr_q[req_idx]   <= rr_q[req_idx] + WAY_W'(1);
                            plru_q[req_idx] <= plru_touch(plru_q[req_idx], victim_q);
                            proc_ready_q    <= 1'b1;
                            state_q         <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign proc_ready    = proc_ready_q;
    assign proc_rdata    = proc_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_icache_nway_plru.sv
// Directed bench for icache_nway_plru: PLRU instance (dut0) and round-robin instance (dut1)
// with a cycle-accurate memory responder folded into the fetch task.
module tb_icache_nway_plru;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pv  [2];
    logic [31:0] pa  [2];
    logic        fl  [2];
    logic        mr  [2];
    logic [31:0] mrd [2];
    logic        prdy[2];
    logic [31:0] prd [2];
    logic        mv  [2];
    logic [31:0] ma  [2];
    logic [31:0] hc  [2];
    logic [31:0] mc  [2];

    int          checks   = 0;
    int          failures = 0;

    int          f_lat;
    int          f_pulses;
    int          f_mvc;
    logic [31:0] f_rdata;
    logic [31:0] f_beats[$];

    always #5 clk = ~clk;

    icache_nway_plru #(.REPL_POLICY(1)) dut0 (
        .clk(clk), .resetn(resetn),
        .proc_valid(pv[0]), .proc_ready(prdy[0]), .proc_addr(pa[0]), .proc_rdata(prd[0]),
        .flush_req(fl[0]),
        .mem_req_valid(mv[0]), .mem_req_ready(mr[0]), .mem_req_addr(ma[0]), .mem_req_rdata(mrd[0]),
        .hit_count(hc[0]), .miss_count(mc[0])
    );

    icache_nway_plru #(.REPL_POLICY(0)) dut1 (
        .clk(clk), .resetn(resetn),
        .proc_valid(pv[1]), .proc_ready(prdy[1]), .proc_addr(pa[1]), .proc_rdata(prd[1]),
        .flush_req(fl[1]),
        .mem_req_valid(mv[1]), .mem_req_ready(mr[1]), .mem_req_addr(ma[1]), .mem_req_rdata(mrd[1]),
        .hit_count(hc[1]), .miss_count(mc[1])
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // One fetch; memory answers each beat 3 cycles after mem_req_valid rises.
    task automatic fetch(input int inst, input logic [31:0] a, input int drop_after, input int flush_beat);
        int vcnt;
        int post;
        int nb;
        vcnt = 0; post = 0; nb = 0;
        f_lat = -1; f_pulses = 0; f_mvc = 0; f_rdata = '0;
        f_beats.delete();
        pa[inst] = a;
        pv[inst] = 1'b1;
        for (int c = 1; c <= 300 && post < 4; c++) begin
            @(negedge clk);
            fl[inst] = 1'b0;
            if (prdy[inst]) begin
                f_pulses++;
                if (f_lat < 0) begin
                    f_lat   = c;
                    f_rdata = prd[inst];
                end
                pv[inst] = 1'b0;
            end
            if (f_lat >= 0) post++;
            if (drop_after > 0 && c == drop_after) pv[inst] = 1'b0;
            if (mv[inst]) f_mvc++;
            if (mr[inst]) begin
                mr[inst] = 1'b0;
                vcnt     = 0;
            end else if (mv[inst]) begin
                vcnt++;
                if (vcnt == 3) begin
                    mr[inst]  = 1'b1;
                    mrd[inst] = memw(ma[inst]);
                    f_beats.push_back(ma[inst]);
                    if (nb == flush_beat) fl[inst] = 1'b1;
                    nb++;
                end
            end
        end
        pv[inst] = 1'b0;
        mr[inst] = 1'b0;
        fl[inst] = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (prdy[0] !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", prdy[0]); end
        checks++; if (mv[0] !== 1'b0) begin failures++; $display("FAIL reset_mvalid: got %b want 0", mv[0]); end
        checks++; if (ma[0] !== 32'h0) begin failures++; $display("FAIL reset_maddr: got %h want 0", ma[0]); end
        checks++; if (prd[0] !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", prd[0]); end
        checks++; if (hc[0] !== 32'h0 || mc[0] !== 32'h0) begin failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hc[0], mc[0]); end
    endtask

    task automatic test_cold_fill;
        logic [31:0] exp [4];
        exp = '{32'h100, 32'h104, 32'h108, 32'h10C};
        fetch(0, 32'h100, 0, -1);
        checks++; if (f_pulses !== 1) begin failures++; $display("FAIL cold_pulses: got %0d want 1", f_pulses); end
        checks++; if (f_beats.size() !== 4) begin failures++; $display("FAIL cold_nbeats: got %0d want 4", f_beats.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= f_beats.size() || f_beats[i] !== exp[i]) begin
                failures++; $display("FAIL cold_beat%0d: got %h want %h", i, (i < f_beats.size()) ? f_beats[i] : 32'hX, exp[i]);
            end
        end
        checks++; if (f_rdata !== memw(32'h100)) begin failures++; $display("FAIL cold_rdata: got %h want %h", f_rdata, memw(32'h100)); end
        checks++; if (mc[0] !== 32'd1 || hc[0] !== 32'd0) begin failures++; $display("FAIL cold_counts: got hit=%0d miss=%0d want 0/1", hc[0], mc[0]); end
    endtask

    task automatic test_critical_word;
        logic [31:0] exp [4];
        exp = '{32'h208, 32'h20C, 32'h200, 32'h204};
        fetch(0, 32'h208, 0, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= f_beats.size() || f_beats[i] !== exp[i]) begin
                failures++; $display("FAIL cwf_beat%0d: got %h want %h", i, (i < f_beats.size()) ? f_beats[i] : 32'hX, exp[i]);
            end
        end
        checks++; if (f_rdata !== memw(32'h208)) begin failures++; $display("FAIL cwf_rdata: got %h want %h", f_rdata, memw(32'h208)); end
    endtask

    task automatic test_hit;
        fetch(0, 32'h104, 0, -1);
        checks++; if (f_lat !== 2) begin failures++; $display("FAIL hit_latency: got %0d want 2", f_lat); end
        checks++; if (f_mvc !== 0) begin failures++; $display("FAIL hit_no_mem: got %0d mem cycles want 0", f_mvc); end
        checks++; if (f_rdata !== memw(32'h104)) begin failures++; $display("FAIL hit_rdata: got %h want %h", f_rdata, memw(32'h104)); end
        fetch(0, 32'h20C, 0, -1);
        checks++; if (f_rdata !== memw(32'h20C) || f_mvc !== 0) begin failures++; $display("FAIL hit2: got %h mem=%0d want %h mem=0", f_rdata, f_mvc, memw(32'h20C)); end
        checks++; if (hc[0] !== 32'd2 || mc[0] !== 32'd2) begin failures++; $display("FAIL hit_counts: got hit=%0d miss=%0d want 2/2", hc[0], mc[0]); end
    endtask

    task automatic test_back_to_back;
        int          c1;
        int          c2;
        logic [31:0] r1;
        logic [31:0] r2;
        c1 = 0; c2 = 0; r1 = '0; r2 = '0;
        pa[0] = 32'h108;
        pv[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (prdy[0]) begin c1 = c; r1 = prd[0]; break; end
        end
        pa[0] = 32'h200;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (prdy[0]) begin c2 = c; r2 = prd[0]; break; end
        end
        pv[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (c1 !== 2 || r1 !== memw(32'h108)) begin failures++; $display("FAIL b2b_first: got lat=%0d data=%h want 2 %h", c1, r1, memw(32'h108)); end
        checks++; if (c2 !== 3) begin failures++; $display("FAIL b2b_gap: got %0d want 3", c2); end
        checks++; if (r2 !== memw(32'h200)) begin failures++; $display("FAIL b2b_second: got %h want %h", r2, memw(32'h200)); end
        checks++; if (hc[0] !== 32'd4) begin failures++; $display("FAIL b2b_hits: got %0d want 4", hc[0]); end
    endtask

    // Five tags in set 1; way0 re-touched before the fifth fill.
    task automatic test_repl(input int inst);
        logic [31:0] seq  [10];
        logic        miss [10];
        if (inst == 0) begin
            seq  = '{32'h010, 32'h210, 32'h410, 32'h610, 32'h010, 32'h810, 32'h010, 32'h210, 32'h610, 32'h410};
            miss = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            seq  = '{32'h010, 32'h210, 32'h410, 32'h610, 32'h010, 32'h810, 32'h210, 32'h410, 32'h610, 32'h010};
            miss = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        end
        for (int i = 0; i < 10; i++) begin
            fetch(inst, seq[i], 0, -1);
            checks++;
            if (f_beats.size() !== (miss[i] ? 4 : 0)) begin
                failures++; $display("FAIL repl%0d_step%0d_%h: got %0d beats want %0d", inst, i, seq[i], f_beats.size(), miss[i] ? 4 : 0);
            end
            checks++;
            if (f_rdata !== memw(seq[i])) begin
                failures++; $display("FAIL repl%0d_rdata%0d: got %h want %h", inst, i, f_rdata, memw(seq[i]));
            end
        end
        if (inst == 0) begin
            checks++; if (hc[0] !== 32'd8 || mc[0] !== 32'd8) begin failures++; $display("FAIL plru_counts: got hit=%0d miss=%0d want 8/8", hc[0], mc[0]); end
        end else begin
            checks++; if (hc[1] !== 32'd4 || mc[1] !== 32'd6) begin failures++; $display("FAIL rr_counts: got hit=%0d miss=%0d want 4/6", hc[1], mc[1]); end
        end
    endtask

    task automatic test_flush_refill;
        fetch(0, 32'h300, 0, 1);
        checks++; if (f_pulses !== 1 || f_beats.size() !== 4) begin failures++; $display("FAIL flref_complete: got pulses=%0d beats=%0d want 1/4", f_pulses, f_beats.size()); end
        checks++; if (f_rdata !== memw(32'h300)) begin failures++; $display("FAIL flref_rdata: got %h want %h", f_rdata, memw(32'h300)); end
        fetch(0, 32'h300, 0, -1);
        checks++; if (f_beats.size() !== 4) begin failures++; $display("FAIL flref_refetch: got %0d beats want 4", f_beats.size()); end
        fetch(0, 32'h100, 0, -1);
        checks++; if (f_beats.size() !== 4) begin failures++; $display("FAIL flref_other: got %0d beats want 4", f_beats.size()); end
        checks++; if (mc[0] !== 32'd11) begin failures++; $display("FAIL flref_misses: got %0d want 11", mc[0]); end
    endtask

    task automatic test_flush_idle;
        @(negedge clk);
        fl[0] = 1'b1;
        @(negedge clk);
        fl[0] = 1'b0;
        fetch(0, 32'h300, 0, -1);
        checks++; if (f_beats.size() !== 4) begin failures++; $display("FAIL flidle_miss: got %0d beats want 4", f_beats.size()); end
        checks++; if (f_rdata !== memw(32'h300)) begin failures++; $display("FAIL flidle_rdata: got %h want %h", f_rdata, memw(32'h300)); end
    endtask

    task automatic test_drop_valid;
        fetch(0, 32'h400, 3, -1);
        checks++; if (f_pulses !== 1 || f_beats.size() !== 4) begin failures++; $display("FAIL drop_complete: got pulses=%0d beats=%0d want 1/4", f_pulses, f_beats.size()); end
        fetch(0, 32'h404, 0, -1);
        checks++; if (f_beats.size() !== 0 || f_rdata !== memw(32'h404)) begin failures++; $display("FAIL drop_installed: got beats=%0d data=%h want 0 %h", f_beats.size(), f_rdata, memw(32'h404)); end
        checks++; if (hc[0] !== 32'd9 || mc[0] !== 32'd13) begin failures++; $display("FAIL drop_counts: got hit=%0d miss=%0d want 9/13", hc[0], mc[0]); end
    endtask

    task automatic test_reset_mid_refill;
        int seen;
        seen = 0;
        pa[0] = 32'h500;
        pv[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mv[0]) begin seen = 1; break; end
        end
        @(negedge clk);
        checks++; if (seen !== 1 || mv[0] !== 1'b1) begin failures++; $display("FAIL rstmid_started: got seen=%0d mvalid=%b want 1/1", seen, mv[0]); end
        resetn = 1'b0;
        #1;
        checks++; if (mv[0] !== 1'b0 || ma[0] !== 32'h0) begin failures++; $display("FAIL rstmid_abort: got mvalid=%b addr=%h want 0/0", mv[0], ma[0]); end
        checks++; if (hc[0] !== 32'd0 || mc[0] !== 32'd0) begin failures++; $display("FAIL rstmid_counters: got %0d/%0d want 0/0", hc[0], mc[0]); end
        pv[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        fetch(0, 32'h500, 0, -1);
        checks++; if (f_beats.size() !== 4) begin failures++; $display("FAIL rstmid_refetch: got %0d beats want 4", f_beats.size()); end
        fetch(0, 32'h100, 0, -1);
        checks++; if (f_beats.size() !== 4) begin failures++; $display("FAIL rstmid_allmiss: got %0d beats want 4", f_beats.size()); end
        checks++; if (mc[0] !== 32'd2 || hc[0] !== 32'd0) begin failures++; $display("FAIL rstmid_counts: got hit=%0d miss=%0d want 0/2", hc[0], mc[0]); end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        force dut0.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut0.hit_cnt_q;
        fetch(0, 32'h500, 0, -1);
        checks++; if (hc[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_reach: got %h want ffffffff", hc[0]); end
        fetch(0, 32'h504, 0, -1);
        checks++; if (hc[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold: got %h want ffffffff", hc[0]); end
        checks++; if (mc[0] !== 32'd2 || f_beats.size() !== 0) begin failures++; $display("FAIL sat_miss: got miss=%0d beats=%0d want 2/0", mc[0], f_beats.size()); end
    endtask

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0; pa[i] = '0; fl[i] = 1'b0; mr[i] = 1'b0; mrd[i] = '0;
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset;
        test_cold_fill;
        test_critical_word;
        test_hit;
        test_back_to_back;
        test_repl(0);
        test_repl(1);
        test_flush_refill;
        test_flush_idle;
        test_drop_valid;
        test_reset_mid_refill;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
